// File: rtl/dc1_pkg.sv
// rtl/dc1_pkg.sv - shared types and constants for the L1 D-cache write scheduler
package dc1_pkg;
    typedef enum logic [1:0] {INIT, RUN, DRAIN} dc1_ws_state_t;

    localparam int DC1_SETS       = 64;
    localparam int DC1_LINE_BYTES = 64;
    localparam int DC1_IDX_W      = $clog2(DC1_SETS);

    typedef struct packed {
        logic [DC1_IDX_W-1:0]        addr;
        logic [DC1_LINE_BYTES-1:0]   mask;
        logic [DC1_LINE_BYTES*8-1:0] data;
    } dc1_st_entry_t;
endpackage

// File: rtl/dc1_wr_sched_if.sv
// rtl/dc1_wr_sched_if.sv - fill/store/flush requests and array write port bundle
interface dc1_wr_sched_if
    import dc1_pkg::*;
#(
    parameter int NPHYS = 55
);
    logic                        fill_req;
    logic [DC1_IDX_W-1:0]        fill_addr;
    logic [DC1_LINE_BYTES*8-1:0] fill_data;
    logic [NPHYS-13:0]           fill_tag;
    logic                        fill_ack;
    logic                        st_req;
    logic [DC1_IDX_W-1:0]        st_addr;
    logic [DC1_LINE_BYTES-1:0]   st_mask;
    logic [DC1_LINE_BYTES*8-1:0] st_data;
    logic                        st_ack;
    logic                        flush_req;
    logic                        init_busy;
    logic                        x_wen;
    logic [DC1_IDX_W-1:0]        x_waddr0;
    logic [DC1_LINE_BYTES*8-1:0] x_din0;
    logic [DC1_LINE_BYTES-1:0]   x_wenb;
    logic [DC1_IDX_W-1:0]        x_waddr1;
    logic [DC1_LINE_BYTES*8-1:0] x_din1;
    logic                        t_wen;
    logic [DC1_IDX_W-1:0]        t_waddr;
    logic [NPHYS-13:0]           t_din;

    modport master (
        output fill_req, fill_addr, fill_data, fill_tag,
        output st_req, st_addr, st_mask, st_data, flush_req,
        input  fill_ack, st_ack, init_busy,
        input  x_wen, x_waddr0, x_din0, x_wenb, x_waddr1, x_din1,
        input  t_wen, t_waddr, t_din
    );

    modport slave (
        input  fill_req, fill_addr, fill_data, fill_tag,
        input  st_req, st_addr, st_mask, st_data, flush_req,
        output fill_ack, st_ack, init_busy,
        output x_wen, x_waddr0, x_din0, x_wenb, x_waddr1, x_din1,
        output t_wen, t_waddr, t_din
    );
endinterface

// File: rtl/dc1_st_fifo.sv
// rtl/dc1_st_fifo.sv - store queue; wrapping pointers with a separate occupancy count
module dc1_st_fifo
    import dc1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  dc1_st_entry_t push_entry,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output dc1_st_entry_t head
);
    localparam int PW = $clog2(DEPTH);

    dc1_st_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/dc1_wr_sched.sv
// rtl/dc1_wr_sched.sv - shared write-port scheduler for the D-cache data and tag arrays
module dc1_wr_sched
    import dc1_pkg::*;
#(
    parameter int NPHYS        = 55,
    parameter int SQ_DEPTH     = 4,
    parameter int MAX_FILL_RUN = 8
) (
    input logic             clk,
    input logic             reset,
    dc1_wr_sched_if.slave   bus
);
    localparam int RW = $clog2(MAX_FILL_RUN + 1);

    dc1_ws_state_t        state, state_nxt;
    logic [DC1_IDX_W-1:0] init_cnt, cnt_nxt;
    logic [RW-1:0]        run_cnt, run_nxt;
    logic                 active, force_st, fill_grant, st_issue, st_ack_c;
    logic                 full, empty;
    dc1_st_entry_t        head, push_entry;

    assign push_entry = '{addr: bus.st_addr, mask: bus.st_mask, data: bus.st_data};

    dc1_st_fifo #(.DEPTH(SQ_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (bus.st_req && st_ack_c),
        .push_entry (push_entry),
        .pop        (st_issue),
        .full       (full),
        .empty      (empty),
        .head       (head)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = init_cnt;
        st_ack_c   = 1'b0;
        active     = 1'b0;
        unique case (state)
            INIT: begin
                cnt_nxt = init_cnt + 1'b1;
                if (bus.flush_req)                             cnt_nxt   = '0;
                else if (init_cnt == DC1_IDX_W'(DC1_SETS - 1)) state_nxt = RUN;
            end
            RUN: begin
                active   = 1'b1;
                st_ack_c = !full;
                if (bus.flush_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                active = 1'b1;
                if (empty) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = INIT;
        endcase

        // A store starved by MAX_FILL_RUN fills jumps ahead, unless it targets the line being filled.
        force_st   = active && !empty && (run_cnt == RW'(MAX_FILL_RUN)) && (head.addr != bus.fill_addr);
        fill_grant = active && bus.fill_req && !force_st;
        st_issue   = active && !empty && !fill_grant;

        run_nxt = run_cnt;
        if (empty || st_issue)                                run_nxt = '0;
        else if (fill_grant && run_cnt != RW'(MAX_FILL_RUN)) run_nxt = run_cnt + 1'b1;
    end

    assign bus.fill_ack  = fill_grant;
    assign bus.st_ack    = st_ack_c;
    assign bus.init_busy = (state != RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
            run_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= cnt_nxt;
            run_cnt  <= run_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.x_wen    <= 1'b0;
            bus.x_waddr0 <= '0;
            bus.x_din0   <= '0;
            bus.x_wenb   <= '0;
            bus.x_waddr1 <= '0;
            bus.x_din1   <= '0;
            bus.t_wen    <= 1'b0;
            bus.t_waddr  <= '0;
            bus.t_din    <= '0;
        end else begin
            bus.x_wen  <= fill_grant;
            bus.x_wenb <= st_issue ? head.mask : '0;
            bus.t_wen  <= (state == INIT) || fill_grant;
            if (fill_grant) begin
                bus.x_waddr0 <= bus.fill_addr;
                bus.x_din0   <= bus.fill_data;
            end
            if (st_issue) begin
                bus.x_waddr1 <= head.addr;
                bus.x_din1   <= head.data;
            end
            if (state == INIT) begin
                bus.t_waddr <= init_cnt;
                bus.t_din   <= '0;
            end else if (fill_grant) begin
                bus.t_waddr <= bus.fill_addr;
                bus.t_din   <= bus.fill_tag;
            end
        end
    end
endmodule
